// File: rtl/test_port_writer.sv
// Streams a framed result sequence (BEGIN_SYMBOL, buffered payload, END_SYMBOL) onto the test port.
// Optional: define TEST_PORT_WRITER_CHECKSUM_EN to append a payload checksum word before END_SYMBOL.
module test_port_writer #(
    parameter logic [29:0] TEST_PORT    = 30'h3FF,
    parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
    parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        push_valid,
    input  logic [31:0] push_data,
    input  logic        push_last,
    output logic        push_ready,
    input  logic        stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StBegin, StPayload, StGap, StCksum, StEnd, StDone
    } state_e;

`ifdef TEST_PORT_WRITER_CHECKSUM_EN
    localparam state_e AfterLast = StCksum;
`else
    localparam state_e AfterLast = StEnd;
`endif

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Payload FIFO: {last, word} per entry
    logic [32:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, push, pop, head_slot;
    logic [32:0] head;

    state_e      state_q, state_d, gap_next_q, gap_next_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d, sum_q, sum_d;
    logic        wen_q, wen_d, last_q, last_d, accept;
    logic [15:0] word_count_q, word_count_d;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    // A head pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign push_ready = !full || pop;
    assign push       = push_valid && push_ready;
    assign head_slot  = (state_q == StPayload && !wen_q) ||
                        (state_q == StGap && gap_cnt_q == '0 && gap_next_q == StPayload);
    assign pop        = head_slot && !empty;
    assign accept     = wen_q && !stall;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {push_last, push_data};
    end

    always_comb begin
        state_d      = state_q;
        gap_next_d   = gap_next_q;
        gap_cnt_d    = gap_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wen_d        = wen_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        sum_d        = sum_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StBegin;
                    wen_d        = 1'b1;
                    addr_d       = TEST_PORT;
                    data_d       = bswap(BEGIN_SYMBOL);
                    word_count_d = '0;
                    sum_d        = '0;
                end
            end
            StBegin, StCksum, StEnd, StPayload: begin
                if (accept) begin
                    state_d   = StGap;
                    wen_d     = 1'b0;
                    gap_cnt_d = 16'(GAP_CYCLES - 1);
                    case (state_q)
                        StBegin: gap_next_d = StPayload;
                        StCksum: gap_next_d = StEnd;
                        StEnd:   gap_next_d = StDone;
                        default: begin
                            gap_next_d   = last_q ? AfterLast : StPayload;
                            word_count_d = (word_count_q == 16'hFFFF) ? word_count_q
                                                                      : word_count_q + 16'd1;
                            sum_d        = sum_q + bswap(data_q);
                        end
                    endcase
                end
            end
            StGap: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end else begin
                    state_d = gap_next_q;
                    case (gap_next_q)
                        StCksum: begin
                            wen_d  = 1'b1;
                            addr_d = TEST_PORT;
                            data_d = bswap(sum_q);
                        end
                        StEnd: begin
                            wen_d  = 1'b1;
                            addr_d = TEST_PORT;
                            data_d = bswap(END_SYMBOL);
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            wen_d  = 1'b1;
            addr_d = TEST_PORT;
            data_d = bswap(head[31:0]);
            last_d = head[32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            gap_next_q   <= StIdle;
            gap_cnt_q    <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wen_q        <= 1'b0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            gap_next_q   <= gap_next_d;
            gap_cnt_q    <= gap_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wen_q        <= wen_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            sum_q        <= sum_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign addr       = addr_q;
    assign data       = data_q;
    assign wen        = wen_q;
    assign word_count = word_count_q;
    assign busy       = !(state_q inside {StIdle, StDone});
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_test_port_writer.sv
// Bench for test_port_writer: random producer/stall drivers, bus monitor, frame-level reference model.
module tb_test_port_writer;
    localparam logic [29:0] TEST_PORT    = 30'h3FF;
    localparam logic [31:0] BEGIN_SYMBOL = 32'h00000168;
    localparam logic [31:0] END_SYMBOL   = 32'hFFFFFD5D;
    localparam int unsigned GAP_CYCLES   = 1;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0;
    logic        push_valid = 1'b0, push_last = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_ready, wen, busy, done;
    logic [29:0] addr;
    logic [31:0] data;
    logic [15:0] word_count;

    test_port_writer #(
        .TEST_PORT    (TEST_PORT),
        .BEGIN_SYMBOL (BEGIN_SYMBOL),
        .END_SYMBOL   (END_SYMBOL),
        .FIFO_DEPTH   (8),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_last  (push_last),
        .push_ready (push_ready),
        .stall      (stall),
        .addr       (addr),
        .data       (data),
        .wen        (wen),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus byte order is the readable word reversed bytewise
    function automatic logic [31:0] bus(input logic [31:0] w);
        logic [31:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    // Producer: feeds src_q entries {last, word}, randomly throttled
    logic [32:0]  src_q[$];
    int unsigned  push_pct = 0;
    int           n_pushed = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (src_q.size() > 0 && $urandom_range(99) < push_pct) begin
            push_valid = 1'b1;
            {push_last, push_data} = src_q[0];
        end else begin
            push_valid = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst && push_valid && push_ready && src_q.size() > 0) begin
            void'(src_q.pop_front());
            n_pushed++;
        end
    end

    int unsigned stall_pct = 0;
    bit          stall_manual = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!stall_manual) stall = ($urandom_range(99) < stall_pct);
    end

    // Bus monitor: records accepted writes and checks hold/pulse/gap/address rules
    logic [31:0] got_q[$];
    initial begin : monitor
        bit          prev_acc = 1'b0, prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        int unsigned low_cnt = GAP_CYCLES;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_acc  = 1'b0;
                prev_hold = 1'b0;
                low_cnt   = GAP_CYCLES;
            end else begin
                if (prev_hold) begin
                    check("hold_wen", 64'(wen), 64'(1));
                    check("hold_data", 64'(data), 64'(prev_data));
                end
                if (prev_acc) check("wen_pulse", 64'(wen), 64'(0));
                if (wen) begin
                    check("bus_addr", 64'(addr), 64'(TEST_PORT));
                    if (!prev_hold) check("gap_len", 64'(low_cnt >= GAP_CYCLES), 64'(1));
                    low_cnt = 0;
                end else begin
                    low_cnt++;
                end
                if (wen && !stall) got_q.push_back(data);
                prev_acc  = wen && !stall;
                prev_hold = wen && stall;
                prev_data = data;
            end
        end
    end

    // Reference model: frame = BEGIN, payload, [sum], END
    logic [31:0] pay_q[$];
    logic [31:0] exp_q[$];
    int          exp_wc = 0;

    task automatic load_frame();
        logic [31:0] sum = '0;
        exp_q.delete();
        exp_q.push_back(bus(BEGIN_SYMBOL));
        foreach (pay_q[i]) begin
            src_q.push_back({1'(i == pay_q.size() - 1), pay_q[i]});
            exp_q.push_back(bus(pay_q[i]));
            sum += pay_q[i];
        end
`ifdef TEST_PORT_WRITER_CHECKSUM_EN
        exp_q.push_back(bus(sum));
`endif
        exp_q.push_back(bus(END_SYMBOL));
        exp_wc = pay_q.size();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic check_frame(input string tag);
        int n;
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_wc"}, 64'(word_count), 64'(exp_wc));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        got_q.delete();
    endtask

    task automatic rand_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back($urandom);
    endtask

    initial begin
        logic [31:0] lit[$];
        int          k;
        int          cnt;

        // Reset state
        #12;
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_wen", 64'(wen), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_wc", 64'(word_count), 64'(0));
        check("rst_ready", 64'(push_ready), 64'(1));
        @(negedge clk);
        rst = 1'b1;

        // Basic frame 0,1,2,3 pre-buffered
        push_pct = 100;
        pay_q = '{32'd0, 32'd1, 32'd2, 32'd3};
        load_frame();
        k = 0;
        while (n_pushed < 4 && k < 50) begin
            @(negedge clk);
            k++;
        end
        pulse_start();
        wait_done("basic");
        lit = '{32'h68010000, 32'h00000000, 32'h01000000, 32'h02000000, 32'h03000000};
`ifdef TEST_PORT_WRITER_CHECKSUM_EN
        lit.push_back(32'h06000000);
`endif
        lit.push_back(32'h5DFDFFFF);
        check("basic_len", 64'(got_q.size()), 64'(lit.size()));
        foreach (lit[i]) if (i < got_q.size()) check($sformatf("basic_w%0d", i), 64'(got_q[i]), 64'(lit[i]));
        check("basic_wc", 64'(word_count), 64'(4));
        got_q.delete();

        // Stall held for 5 cycles on payload word 0x105
        stall_manual = 1'b1;
        stall = 1'b0;
        pay_q = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
        load_frame();
        pulse_start();
        k = 0;
        while (!(wen && data == bus(32'h105)) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_wen%0d", i), 64'(wen), 64'(1));
            check($sformatf("stall_data%0d", i), 64'(data), 64'(bus(32'h105)));
        end
        @(posedge clk);
        #1 stall = 1'b0;
        wait_done("stall");
        cnt = 0;
        foreach (got_q[i]) if (got_q[i] == bus(32'h105)) cnt++;
        check("stall_once", 64'(cnt), 64'(1));
        check_frame("stall");
        stall_manual = 1'b0;

        // 20 words against an 8-deep FIFO
        n_pushed = 0;
        rand_payload(20);
        load_frame();
        k = 0;
        while (n_pushed < 8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("full_ready", 64'(push_ready), 64'(0));
        check("full_count", 64'(n_pushed), 64'(8));
        pulse_start();
        wait_done("deep");
        check_frame("deep");

        // Reset mid-payload after 2 payload words
        rand_payload(6);
        load_frame();
        pulse_start();
        k = 0;
        while (got_q.size() < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        push_pct = 0;
        src_q.delete();
        rst = 1'b0;
        #1;
        check("abort_wen", 64'(wen), 64'(0));
        check("abort_addr", 64'(addr), 64'(0));
        check("abort_data", 64'(data), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_wc", 64'(word_count), 64'(0));
        check("abort_ready", 64'(push_ready), 64'(1));
        cnt = 0;
        foreach (got_q[i]) if (got_q[i] == bus(END_SYMBOL)) cnt++;
        check("abort_no_end", 64'(cnt), 64'(0));
        got_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        push_pct = 100;
        rand_payload(3);
        load_frame();
        pulse_start();
        wait_done("after_abort");
        check_frame("after_abort");

        // Start while busy is ignored; start in DONE opens a fresh frame
        push_pct = 60;
        rand_payload(5);
        load_frame();
        pulse_start();
        repeat (3) @(negedge clk);
        check("restart_busy", 64'(busy), 64'(1));
        pulse_start();
        wait_done("restart");
        check_frame("restart");
        rand_payload(2);
        load_frame();
        pulse_start();
        @(negedge clk);
        check("new_wc", 64'(word_count), 64'(0));
        check("new_wen", 64'(wen), 64'(1));
        check("new_done", 64'(done), 64'(0));
        wait_done("new");
        check_frame("new");

        // Checksum wrap-around pattern
        pay_q = '{32'd1, 32'd2, 32'hFFFFFFFF};
        load_frame();
        pulse_start();
        wait_done("wrap");
`ifdef TEST_PORT_WRITER_CHECKSUM_EN
        if (got_q.size() >= 2) check("wrap_sum", 64'(got_q[got_q.size() - 2]), 64'(32'h02000000));
        else check("wrap_sum_len", 64'(got_q.size()), 64'(6));
`endif
        check_frame("wrap");

        // Randomized frames with random stall and producer throttling
        for (int f = 0; f < 15; f++) begin
            stall_pct = $urandom_range(50);
            push_pct  = $urandom_range(100, 30);
            rand_payload($urandom_range(12, 1));
            load_frame();
            repeat ($urandom_range(10)) @(posedge clk);
            pulse_start();
            wait_done($sformatf("rnd%0d", f));
            check_frame($sformatf("rnd%0d", f));
        end
        stall_pct = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
